// File: rtl/smem_result_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// smem_result_writer : absorbs SMEM result-queue beats into a FIFO and streams
//                      them as consecutive 64-byte line writes to host memory.
// Revision 1.0
// ----------------------------------------------------------------------------
module smem_result_writer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              output_request,
  output logic              output_permit,
  input  logic [511:0]      output_data,
  input  logic              output_valid,
  input  logic              output_finish,
  output logic              stall,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [511:0]      wr_data,
  input  logic              wr_ready,
  output logic [31:0]       line_count,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_STREAM   = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state;
  logic [511:0]      mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              stall_d;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] addr_cnt;

  // A beat seen while stall_d is high is the queue's frozen copy of the previous one.
  assign accept  = output_valid & ~stall_d & (state == S_STREAM);
  assign wr_req  = (count != '0);
  assign pop     = wr_req & wr_ready;
  assign wr_data = wr_req ? mem[rd_ptr] : '0;
  assign wr_addr = addr_cnt;

  always_comb begin
    count_nxt = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= output_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stall   <= 1'b0;
      stall_d <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      stall   <= (count_nxt >= STALL_LVL);
      stall_d <= stall;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      output_permit <= 1'b0;
      done          <= 1'b0;
      addr_cnt      <= '0;
      line_count    <= '0;
    end else begin
      if (pop) begin
        addr_cnt <= addr_cnt + 1'b1;
        if (line_count != '1) begin
          line_count <= line_count + 1'b1;
        end
      end
      // The FIFO is always empty in IDLE/DONE, so start never collides with a pop.
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr_cnt   <= base_addr;
            line_count <= '0;
            done       <= 1'b0;
            state      <= S_WAIT_REQ;
          end
        end
        S_WAIT_REQ: begin
          if (output_request) begin
            state         <= S_STREAM;
            output_permit <= 1'b1;
          end
        end
        S_STREAM: begin
          if (output_finish && !accept) begin
            state         <= S_DRAIN;
            output_permit <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!wr_req) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          output_permit <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smem_result_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_smem_result_writer : table-driven and randomized checks of smem_result_writer
//                         against a beat-list / write-list reference model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_smem_result_writer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              output_request;
  logic              output_permit;
  logic [511:0]      output_data;
  logic              output_valid;
  logic              output_finish;
  logic              stall;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [511:0]      wr_data;
  logic              wr_ready;
  logic [31:0]       line_count;
  logic              done;

  always #5 clk = ~clk;

  smem_result_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .output_request(output_request), .output_permit(output_permit),
    .output_data(output_data), .output_valid(output_valid),
    .output_finish(output_finish), .stall(stall), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .line_count(line_count), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the batch is a list of beats; the host must see exactly
  // that list, in order, at base, base+1, ...
  logic [511:0]      beats[$];
  int                idx;
  int                writes;
  int                gap_pct;
  int                rdy_pct;
  int                max_occ;
  logic [ADDR_W-1:0] exp_addr;
  bit                hold_prev;
  logic [ADDR_W-1:0] hold_addr;
  logic [511:0]      hold_data;

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: check any write happening at this edge, then advance the queue.
  task automatic tick();
    bit st_prev;
    bit pm_prev;
    bit xfer;
    st_prev = stall;
    pm_prev = output_permit;
    if (hold_prev) begin
      check("hold_req_addr", 512'({wr_req, wr_addr}), 512'({1'b1, hold_addr}));
      check("hold_data", wr_data, hold_data);
    end
    xfer = wr_req && wr_ready;
    if (xfer) begin
      check("wr_addr", 512'(wr_addr), 512'(exp_addr));
      check("wr_data", wr_data, (writes < beats.size()) ? beats[writes] : '0);
    end
    hold_prev = wr_req && !wr_ready;
    hold_addr = wr_addr;
    hold_data = wr_data;
    @(posedge clk);
    #1;
    if (xfer) begin
      writes++;
      exp_addr++;
    end
    // The queue's output registers move only on edges where stall was low.
    if (!st_prev) begin
      if (pm_prev && idx < beats.size() && int'($urandom_range(99)) >= gap_pct) begin
        output_valid = 1'b1;
        output_data  = beats[idx];
        idx++;
      end else begin
        output_valid = 1'b0;
        output_data  = rand_line();
        if (pm_prev && idx == beats.size()) output_finish = 1'b1;
      end
    end
    wr_ready = (int'($urandom_range(99)) < rdy_pct);
    if (idx - writes > max_occ) max_occ = idx - writes;
  endtask

  task automatic begin_batch(input logic [ADDR_W-1:0] base, input int n, input int gap, input int rdy);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(rand_line());
    idx = 0; writes = 0; max_occ = 0; exp_addr = base; hold_prev = 1'b0;
    gap_pct = gap; rdy_pct = rdy;
    output_valid = 1'b0; output_finish = 1'b0; output_request = 1'b0;
    wr_ready  = (int'($urandom_range(99)) < rdy_pct);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_done", 512'(done), 512'(0));
    check("start_clears_count", 512'(line_count), 512'(0));
    output_request = 1'b1;
  endtask

  task automatic finish_batch(input string nm, input int exp_lines, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    check({nm, "_done"}, 512'(done), 512'(1));
    check({nm, "_writes"}, 512'(writes), 512'(exp_lines));
    check({nm, "_line_count"}, 512'(line_count), 512'(exp_lines));
    check({nm, "_idle_wr_req"}, 512'(wr_req), 512'(0));
    check({nm, "_no_overflow"}, 512'(max_occ <= DEPTH), 512'(1));
    output_request = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                n;
    int                gap;
    int                rdy;
    int                exp_lines;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c;
    vecs[0] = '{32'h0000_1000,  5, 40, 100,  5};
    vecs[1] = '{32'hFFFF_FFFE,  4, 20, 100,  4};
    vecs[2] = '{32'h0000_2000, 30, 10,  30, 30};
    vecs[3] = '{32'h0000_0040, 12, 50,  70, 12};
    vecs[4] = '{32'h0000_0000,  1,  0, 100,  1};

    reset = 1'b1; start = 1'b0; base_addr = '0; output_request = 1'b0;
    output_data = '0; output_valid = 1'b0; output_finish = 1'b0; wr_ready = 1'b0;
    beats.delete(); idx = 0; writes = 0; gap_pct = 0; rdy_pct = 0;
    max_occ = 0; exp_addr = '0; hold_prev = 1'b0; hold_addr = '0; hold_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_permit", 512'(output_permit), 512'(0));
    check("rst_stall", 512'(stall), 512'(0));
    check("rst_wr_req", 512'(wr_req), 512'(0));
    check("rst_wr_addr", 512'(wr_addr), 512'(0));
    check("rst_wr_data", wr_data, '0);
    check("rst_line_count", 512'(line_count), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      begin_batch(vecs[i].base, vecs[i].n, vecs[i].gap, vecs[i].rdy);
      finish_batch($sformatf("vec%0d", i), vecs[i].exp_lines, 2000);
    end

    // Back-pressure: host blocked, queue keeps offering beats; held beats while
    // stall is high must not be written twice.
    begin_batch(32'h0000_8000, 20, 0, 0);
    for (int i = 0; i < 40; i++) tick();
    check("bp_stall_high", 512'(stall), 512'(1));
    check("bp_occupancy", 512'(idx - writes), 512'(DEPTH - 1));
    check("bp_no_writes", 512'(writes), 512'(0));
    check("bp_wr_req", 512'(wr_req), 512'(1));
    rdy_pct = 100;
    finish_batch("bp", 20, 500);

    // Empty batch: finish already high on entry.
    begin_batch(32'h0000_7000, 0, 0, 100);
    output_finish = 1'b1;
    c = 0;
    while (!done && c < 10) begin
      tick();
      c++;
    end
    check("empty_latency_le3", 512'(c <= 3), 512'(1));
    finish_batch("empty", 0, 10);

    // Reset in the middle of a stream, then restart from a new base.
    begin_batch(32'h0000_3000, 6, 0, 0);
    c = 0;
    while (idx < 3 && c < 50) begin
      tick();
      c++;
    end
    wr_ready = 1'b1;
    tick();
    check("mid_one_written", 512'(writes), 512'(1));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_permit", 512'(output_permit), 512'(0));
    check("mid_rst_stall", 512'(stall), 512'(0));
    check("mid_rst_wr_req", 512'(wr_req), 512'(0));
    check("mid_rst_wr_addr", 512'(wr_addr), 512'(0));
    check("mid_rst_wr_data", wr_data, '0);
    check("mid_rst_line_count", 512'(line_count), 512'(0));
    check("mid_rst_done", 512'(done), 512'(0));
    output_request = 1'b0; output_valid = 1'b0; output_finish = 1'b0; hold_prev = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    begin_batch(32'h0000_5000, 4, 25, 80);
    finish_batch("post_rst", 4, 500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
